// File: rtl/mux_8_2_1_sequencer.sv
// Feeds an 8:1 mux with a held word, walks its select at a programmable bit rate and
// serializes the mux output, flagging any sampled bit that differs from the held word.
module mux_8_2_1_sequencer #(
  parameter int unsigned BIT_PERIOD = 1,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_in_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [7:0] mux_in_o,
  output logic [2:0] mux_sel_o,
  input  logic       mux_out_i,
  output logic       ser_out_o,
  output logic       ser_valid_o,
  output logic       frame_done_o,
  input  logic       err_clr_i,
  output logic       mismatch_err_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [3:0] DivLast  = 4'(BIT_PERIOD - 1);
  localparam logic [2:0] FirstSel = MSB_FIRST ? 3'd7 : 3'd0;

  state_e     state_q, state_d;
  logic [7:0] mux_in_q, mux_in_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] div_q, div_d;
  logic       ser_out_q, ser_out_d;
  logic       ser_valid_q, ser_valid_d;
  logic       err_q, err_d;

  logic accept, sample, mismatch;

  assign accept   = (state_q == StIdle) && data_valid_i;
  assign sample   = (state_q == StShift) && (div_q == DivLast);
  assign mismatch = sample && (mux_out_i != mux_in_q[sel_q]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (sample && (idx_q == 3'd7)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_ready_o = (state_q == StIdle);
    frame_done_o = (state_q == StDone);
  end

  always_comb begin
    mux_in_d    = mux_in_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    div_d       = div_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = 1'b0;
    if (accept) begin
      mux_in_d = data_in_i;
      sel_d    = FirstSel;
      idx_d    = 3'd0;
      div_d    = 4'd0;
    end else if (state_q == StShift) begin
      if (sample) begin
        ser_out_d   = mux_out_i;
        ser_valid_d = 1'b1;
        idx_d       = idx_q + 3'd1;
        div_d       = 4'd0;
        // Select parks on the last position once the final bit is taken.
        if (idx_q != 3'd7) sel_d = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
      end else begin
        div_d = div_q + 4'd1;
      end
    end
    // A fresh mismatch beats a coincident clear.
    if (mismatch) err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else err_d = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mux_in_q    <= 8'h00;
      sel_q       <= 3'b000;
      idx_q       <= 3'd0;
      div_q       <= 4'd0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mux_in_q    <= mux_in_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      div_q       <= div_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      err_q       <= err_d;
    end
  end

  assign mux_in_o       = mux_in_q;
  assign mux_sel_o      = sel_q;
  assign ser_out_o      = ser_out_q;
  assign ser_valid_o    = ser_valid_q;
  assign mismatch_err_o = err_q;

endmodule

// File: tb/tb_mux_8_2_1_sequencer.sv
// Scoreboard bench: instance 0 runs P=1 LSB-first, instance 1 runs P=3 MSB-first; a
// behavioural mux closes the loop and an injectable fault forces its output low.
module tb_mux_8_2_1_sequencer;

  typedef struct packed {
    logic        b;
    logic [31:0] cyc;
    logic        last;
  } exp_t;

  logic       clk, rst_n;
  logic [7:0] data_in    [2];
  logic       data_valid [2];
  logic       data_ready [2];
  logic [7:0] mux_in     [2];
  logic [2:0] mux_sel    [2];
  logic       mux_out    [2];
  logic       ser_out    [2];
  logic       ser_valid  [2];
  logic       frame_done [2];
  logic       err_clr    [2];
  logic       merr       [2];
  logic       fault      [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mux_8_2_1_sequencer #(
      .BIT_PERIOD((g == 0) ? 1 : 3),
      .MSB_FIRST ((g == 0) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_in_i     (data_in[g]),
      .data_valid_i  (data_valid[g]),
      .data_ready_o  (data_ready[g]),
      .mux_in_o      (mux_in[g]),
      .mux_sel_o     (mux_sel[g]),
      .mux_out_i     (mux_out[g]),
      .ser_out_o     (ser_out[g]),
      .ser_valid_o   (ser_valid[g]),
      .frame_done_o  (frame_done[g]),
      .err_clr_i     (err_clr[g]),
      .mismatch_err_o(merr[g])
    );
    assign mux_out[g] = fault[g] ? 1'b0 : mux_in[g][mux_sel[g]];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int period(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Monitor: every ser_valid pulse must match the oldest expected bit, its cycle and frame end.
  task automatic mon(input int i);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : q1.size();
    if (ser_valid[i]) begin
      if (n == 0) begin
        chk($sformatf("unexpected_bit%0d", i), 32'(ser_valid[i]), 32'd0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("ser_out%0d", i), 32'(ser_out[i]), 32'(e.b));
        chk($sformatf("bit_cycle%0d", i), cyc, e.cyc);
        chk($sformatf("frame_done%0d", i), 32'(frame_done[i]), 32'(e.last));
      end
    end else if (frame_done[i]) begin
      chk($sformatf("stray_frame_done%0d", i), 32'(frame_done[i]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic push_frame(input int i, input logic [7:0] w, input int e0);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.b    = fault[i] ? 1'b0 : ((i == 1) ? w[7-k] : w[k]);
      e.cyc  = 32'(e0 + (k + 1) * period(i));
      e.last = (k == 7);
      if (i == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Present a word, wait (bounded) for ready, and return the accepting edge index.
  task automatic send(input int i, input logic [7:0] w, input bit hold, output int e0);
    int n;
    n = 0;
    data_in[i]    = w;
    data_valid[i] = 1'b1;
    while (data_ready[i] !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk($sformatf("ready_timeout%0d", i), 32'(data_ready[i]), 32'd1);
        data_valid[i] = 1'b0;
        e0 = -1;
        return;
      end
    end
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    data_valid[i] = hold;
    data_in[i]    = 8'($urandom);
    push_frame(i, w, e0);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (((i == 0) ? q0.size() : q1.size()) != 0 || data_ready[i] !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk($sformatf("idle_timeout%0d", i), 32'(data_ready[i]), 32'd1);
        return;
      end
    end
  endtask

  // Follows a frame from its accept edge: select walk, busy DONE cycle, ready afterwards.
  task automatic check_frame(input int i, input logic [7:0] w, input int e0);
    int p;
    p = period(i);
    for (int j = 0; j < 8 * p; j++) begin
      @(negedge clk);
      chk($sformatf("sel%0d_j%0d", i, j), 32'(mux_sel[i]),
          (i == 1) ? 32'(7 - j / p) : 32'(j / p));
      chk($sformatf("mux_in%0d", i), 32'(mux_in[i]), 32'(w));
    end
    @(negedge clk);
    chk($sformatf("ready_in_done%0d", i), 32'(data_ready[i]), 32'd0);
    chk($sformatf("done_cycle%0d", i), 32'(frame_done[i]), 32'd1);
    @(negedge clk);
    chk($sformatf("ready_after%0d", i), 32'(data_ready[i]), 32'd1);
    chk($sformatf("frame_len%0d", i), cyc - e0, 32'(8 * p + 1));
  endtask

  task automatic check_reset_vals(input int i);
    chk($sformatf("rst_ready%0d", i), 32'(data_ready[i]), 32'd1);
    chk($sformatf("rst_mux_in%0d", i), 32'(mux_in[i]), 32'd0);
    chk($sformatf("rst_sel%0d", i), 32'(mux_sel[i]), 32'd0);
    chk($sformatf("rst_ser_out%0d", i), 32'(ser_out[i]), 32'd0);
    chk($sformatf("rst_ser_valid%0d", i), 32'(ser_valid[i]), 32'd0);
    chk($sformatf("rst_frame_done%0d", i), 32'(frame_done[i]), 32'd0);
    chk($sformatf("rst_err%0d", i), 32'(merr[i]), 32'd0);
  endtask

  initial begin
    int e0, e1;
    logic [7:0] w;
    for (int i = 0; i < 2; i++) begin
      data_in[i] = 8'h00; data_valid[i] = 1'b0; err_clr[i] = 1'b0; fault[i] = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_reset_vals(0);
    check_reset_vals(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-bit word, P=1, LSB first.
    send(0, 8'h01, 1'b0, e0);
    check_frame(0, 8'h01, e0);
    chk("err_after_01", 32'(merr[0]), 32'd0);

    // 8'hA5, P=3, MSB first, then an immediate follow-on accept.
    send(1, 8'hA5, 1'b0, e0);
    check_frame(1, 8'hA5, e0);
    send(1, 8'h3E, 1'b0, e1);
    chk("a5_frame_26", e1 - e0, 32'd26);
    wait_idle(1);

    // Back-to-back FF then 00 with valid held; second word waits through SHIFT.
    send(0, 8'hFF, 1'b1, e0);
    send(0, 8'h00, 1'b0, e1);
    chk("b2b_accept_gap", e1 - e0, 32'd10);
    wait_idle(0);

    // Stuck-low mux output while serializing FF.
    fault[0] = 1'b1;
    send(0, 8'hFF, 1'b0, e0);
    @(negedge clk);
    chk("err_before_sample", 32'(merr[0]), 32'd0);
    @(negedge clk);
    chk("err_after_sample", 32'(merr[0]), 32'd1);
    repeat (7) @(negedge clk);
    chk("err_held_done", 32'(merr[0]), 32'd1);
    wait_idle(0);
    fault[0] = 1'b0;
    chk("err_sticky_idle", 32'(merr[0]), 32'd1);
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    chk("err_cleared", 32'(merr[0]), 32'd0);

    // Clear coincident with a fresh mismatch leaves the flag set.
    fault[0] = 1'b1;
    send(0, 8'hFF, 1'b0, e0);
    err_clr[0] = 1'b1;
    @(posedge clk);
    #1;
    err_clr[0] = 1'b0;
    @(negedge clk);
    chk("err_set_wins", 32'(merr[0]), 32'd1);
    wait_idle(0);
    fault[0] = 1'b0;
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;

    // Reset after bit 3 of 8'h3C, then 8'h81 accepted on the first edge after release.
    send(0, 8'h3C, 1'b0, e0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals(0);
    q0.delete();
    data_in[0]    = 8'h81;
    data_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    e0 = cyc + 1;
    @(posedge clk);
    #1;
    data_valid[0] = 1'b0;
    push_frame(0, 8'h81, e0);
    check_frame(0, 8'h81, e0);

    // Randomized words, gaps and changing data_in while busy on both instances.
    for (int n = 0; n < 24; n++) begin
      int i;
      i = int'($urandom_range(1, 0));
      w = 8'($urandom);
      repeat ($urandom_range(3, 0)) @(negedge clk);
      send(i, w, 1'b0, e0);
    end
    wait_idle(0);
    wait_idle(1);
    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    chk("final_err0", 32'(merr[0]), 32'd0);
    chk("final_err1", 32'(merr[1]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
